// File: rtl/op_pkg.sv
// Shared opcode definitions for the op_code issuer and decoder.
// Holds the encoding table plus encode/decode helpers.
package op_pkg;

    typedef logic [3:0] op_code_t;
    typedef logic [1:0] source_t;

    localparam op_code_t OP_NOP     = 4'b0000;
    localparam op_code_t OP_WRITE_A = 4'b0001;
    localparam op_code_t OP_WRITE_B = 4'b0010;
    localparam op_code_t OP_READ_C  = 4'b1011;

    typedef struct packed {
        logic     legal;
        op_code_t code;
    } enc_t;

    typedef struct packed {
        logic    valid;
        logic    write;
        source_t source;
    } dec_t;

    // Unknown bits never match an item, so they fall into the illegal default.
    function automatic enc_t op_encode(logic write, source_t source);
        enc_t r;
        r.legal = 1'b1;
        r.code  = OP_NOP;
        case ({write, source})
            3'b100:  r.code = OP_WRITE_A;
            3'b110:  r.code = OP_WRITE_B;
            3'b011:  r.code = OP_READ_C;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    function automatic dec_t op_decode(op_code_t code);
        dec_t r;
        r = '0;
        case (code)
            OP_WRITE_A: r = '{valid: 1'b1, write: 1'b1, source: 2'b00};
            OP_WRITE_B: r = '{valid: 1'b1, write: 1'b1, source: 2'b10};
            OP_READ_C:  r = '{valid: 1'b1, write: 1'b0, source: 2'b11};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Small synchronous FIFO; control state is reset, storage is not.
// Simultaneous push and pop keeps count and advances both pointers.
module op_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q] <= din;
    end

endmodule

// File: rtl/op_code_issuer.sv
// Encodes (write, source) requests into op_codes and issues them in order
// through a FIFO; illegal requests are dropped, flagged and counted.
module op_code_issuer
    import op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_source,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [3:0]       op_code,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    enc_t             enc;
    logic             accept, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_cnt;
    op_code_t         fifo_dout;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign enc       = op_encode(req_write, source_t'(req_source));
    assign req_ready = (fifo_cnt != CW'(DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = accept & enc.legal & ~fifo_full;
    assign op_valid  = ~fifo_empty;
    assign pop       = op_valid & op_ready;
    assign op_code   = op_valid ? fifo_dout : OP_NOP;

    op_fifo #(
        .WIDTH (4),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (enc.code),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        err_d = accept & ~enc.legal;
        cnt_d = cnt_q;
        if (err_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err       = err_q;
    assign err_count = cnt_q;

endmodule
